robo_controlador: RTL and testbench

ROBO_CONTROLADOR -- requirements
Module: robo_controlador

---
 rtl/robo_controlador_if.sv | 37 +++
 rtl/robo_controlador.sv | 155 +++++++++++++++
 tb/tb_robo_controlador.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/robo_controlador_if.sv
// -----------------------------------------------------------------------------
// robo_controlador_if
// Bundles the sensor inputs and the command/status outputs of the maze robot
// controller.
//   master : controller side  (consumes sensors, drives commands and status)
//   slave  : map/robot side   (drives sensors, consumes commands and status)
// Signals:
//   head, left, under, barrier : wall ahead, wall on left, on goal, trash ahead
//   avancar, girar             : one-cycle forward-step / left-turn pulses
//   remover                    : level held while removing the barrier ahead
//   fim, erro                  : sticky goal-reached / removal-timeout flags
//   estado                     : current FSM state code (debug)
//   passos                     : saturating count of forward steps
// -----------------------------------------------------------------------------
interface robo_controlador_if;
  logic        head;
  logic        left;
  logic        under;
  logic        barrier;
  logic        avancar;
  logic        girar;
  logic        remover;
  logic        fim;
  logic        erro;
  logic [2:0]  estado;
  logic [15:0] passos;

  modport master (
    input  head, left, under, barrier,
    output avancar, girar, remover, fim, erro, estado, passos
  );

  modport slave (
    output head, left, under, barrier,
    input  avancar, girar, remover, fim, erro, estado, passos
  );
endinterface

// File: rtl/robo_controlador.sv
// -----------------------------------------------------------------------------
// robo_controlador
// Left-hand wall-following controller for a maze robot. Each decision step
// reads the sensors, then issues a forward step, a left turn, a right turn
// (three left-turn pulses) or a barrier removal. Reaching the goal cell or
// failing to clear a barrier in time parks the FSM until reset.
// Ports:
//   Clock50 : single clock, rising edge
//   Reset   : synchronous, active-high
//   bus     : robo_controlador_if.master (sensors in, commands/status out)
// Every output is driven straight from a register.
// -----------------------------------------------------------------------------
module robo_controlador (
  input  logic               Clock50,
  input  logic               Reset,
  robo_controlador_if.master bus
);

  typedef enum logic [2:0] {
    INICIO   = 3'd0,
    DECIDE   = 3'd1,
    PULSO    = 3'd2,
    ESPERA   = 3'd3,
    GIRA_DIR = 3'd4,
    REMOVE   = 3'd5,
    FIM      = 3'd6,
    ERRO     = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic        virou_q, virou_d;
  logic [2:0]  gcnt_q, gcnt_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic        avancar_q, avancar_d;
  logic        girar_q, girar_d;
  logic        remover_q, remover_d;
  logic        fim_q, fim_d;
  logic        erro_q, erro_d;
  logic [15:0] passos_q, passos_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    if (!inc || v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  // Next-state and next-command logic. Commands are computed for the state
  // being entered so that they appear in the same cycle as that state.
  always_comb begin
    state_d   = state_q;
    virou_d   = virou_q;
    gcnt_d    = gcnt_q;
    rcnt_d    = rcnt_q;
    avancar_d = 1'b0;
    girar_d   = 1'b0;
    remover_d = 1'b0;

    unique case (state_q)
      INICIO: state_d = DECIDE;

      DECIDE: begin
        if (bus.under) begin
          state_d = FIM;
        end else if (!bus.left && !virou_q) begin
          // Remember the left turn so the next step moves into the opening
          // instead of spinning in place.
          virou_d = 1'b1;
          state_d = PULSO;
          girar_d = 1'b1;
        end else if (bus.barrier) begin
          state_d   = REMOVE;
          rcnt_d    = 4'd0;
          remover_d = 1'b1;
        end else if (!bus.head) begin
          virou_d   = 1'b0;
          state_d   = PULSO;
          avancar_d = 1'b1;
        end else begin
          virou_d = 1'b0;
          state_d = GIRA_DIR;
          gcnt_d  = 3'd0;
          girar_d = 1'b1;
        end
      end

      PULSO:  state_d = ESPERA;
      ESPERA: state_d = DECIDE;

      GIRA_DIR: begin
        // Three left pulses on counts 0, 2, 4 make one right turn.
        if (gcnt_q == 3'd5) begin
          state_d = DECIDE;
        end else begin
          gcnt_d  = gcnt_q + 3'd1;
          girar_d = gcnt_q[0];
        end
      end

      REMOVE: begin
        if (!bus.barrier) begin
          state_d = ESPERA;
        end else if (rcnt_q == 4'd15) begin
          state_d = ERRO;
        end else begin
          rcnt_d    = rcnt_q + 4'd1;
          remover_d = 1'b1;
        end
      end

      FIM:  state_d = FIM;
      ERRO: state_d = ERRO;

      default: state_d = INICIO;
    endcase

    fim_d    = (state_d == FIM);
    erro_d   = (state_d == ERRO);
    passos_d = sat_inc(passos_q, avancar_q);
  end

  // State and output registers
  always_ff @(posedge Clock50) begin
    if (Reset) begin
      state_q   <= INICIO;
      virou_q   <= 1'b0;
      gcnt_q    <= 3'd0;
      rcnt_q    <= 4'd0;
      avancar_q <= 1'b0;
      girar_q   <= 1'b0;
      remover_q <= 1'b0;
      fim_q     <= 1'b0;
      erro_q    <= 1'b0;
      passos_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      virou_q   <= virou_d;
      gcnt_q    <= gcnt_d;
      rcnt_q    <= rcnt_d;
      avancar_q <= avancar_d;
      girar_q   <= girar_d;
      remover_q <= remover_d;
      fim_q     <= fim_d;
      erro_q    <= erro_d;
      passos_q  <= passos_d;
    end
  end

  assign bus.avancar = avancar_q;
  assign bus.girar   = girar_q;
  assign bus.remover = remover_q;
  assign bus.fim     = fim_q;
  assign bus.erro    = erro_q;
  assign bus.estado  = state_q;
  assign bus.passos  = passos_q;

endmodule

// File: tb/tb_robo_controlador.sv
// -----------------------------------------------------------------------------
// tb_robo_controlador
// Bench for robo_controlador. A step-level reference model turns one decision
// (the sensor values seen in DECIDE, plus how long a barrier persists) into
// the expected per-cycle trace of {estado, avancar, girar, remover, fim, erro}.
// -----------------------------------------------------------------------------
module tb_robo_controlador;

  logic Clock50 = 1'b0;
  logic Reset   = 1'b1;

  robo_controlador_if bus ();

  robo_controlador dut (
    .Clock50 (Clock50),
    .Reset   (Reset),
    .bus     (bus)
  );

  always #10 Clock50 = ~Clock50;

  int checks = 0;
  int errors = 0;

  // Model state
  bit        m_virou;
  bit        m_term;
  int        m_passos;

  logic [7:0] exp_q[$];
  bit         bar_q[$];
  logic [7:0] obs_q[$];

  function automatic logic [7:0] rec(input int st, input bit av, gi, re, fi, er);
    logic [2:0] s;
    s = st[2:0];
    return {s, av, gi, re, fi, er};
  endfunction

  function automatic logic [7:0] observed();
    return {bus.estado, bus.avancar, bus.girar, bus.remover, bus.fim, bus.erro};
  endfunction

  task automatic tick();
    @(posedge Clock50);
    #1;
  endtask

  task automatic junk_inputs();
    bus.head  = 1'($urandom);
    bus.left  = 1'($urandom);
    bus.under = 1'($urandom);
  endtask

  // Reference model for one decision. k = REMOVE cycle (1-based) in which the
  // barrier is first seen cleared; k > 16 means it never clears.
  task automatic model_step(input bit h, l, u, b, input int k);
    exp_q.delete();
    bar_q.delete();
    if (u) begin
      exp_q.push_back(rec(6, 0, 0, 0, 1, 0)); bar_q.push_back(1'($urandom));
      m_term = 1;
    end else if (!l && !m_virou) begin
      m_virou = 1;
      exp_q.push_back(rec(2, 0, 1, 0, 0, 0)); bar_q.push_back(1'($urandom));
      exp_q.push_back(rec(3, 0, 0, 0, 0, 0)); bar_q.push_back(1'($urandom));
      exp_q.push_back(rec(1, 0, 0, 0, 0, 0)); bar_q.push_back(1'($urandom));
    end else if (b) begin
      for (int j = 1; j <= 16 && j <= k; j++) begin
        exp_q.push_back(rec(5, 0, 0, 1, 0, 0)); bar_q.push_back(j < k);
      end
      if (k <= 16) begin
        exp_q.push_back(rec(3, 0, 0, 0, 0, 0)); bar_q.push_back(1'($urandom));
        exp_q.push_back(rec(1, 0, 0, 0, 0, 0)); bar_q.push_back(1'($urandom));
      end else begin
        exp_q.push_back(rec(7, 0, 0, 0, 0, 1)); bar_q.push_back(1'($urandom));
        m_term = 1;
      end
    end else if (!h) begin
      m_virou = 0;
      exp_q.push_back(rec(2, 1, 0, 0, 0, 0)); bar_q.push_back(1'($urandom));
      exp_q.push_back(rec(3, 0, 0, 0, 0, 0)); bar_q.push_back(1'($urandom));
      exp_q.push_back(rec(1, 0, 0, 0, 0, 0)); bar_q.push_back(1'($urandom));
      if (m_passos < 65535) m_passos++;
    end else begin
      m_virou = 0;
      for (int j = 0; j < 6; j++) begin
        exp_q.push_back(rec(4, 0, (j % 2) == 0, 0, 0, 0)); bar_q.push_back(1'($urandom));
      end
      exp_q.push_back(rec(1, 0, 0, 0, 0, 0)); bar_q.push_back(1'($urandom));
    end
  endtask

  // Drive one decision from DECIDE and record what the DUT shows each cycle.
  task automatic step(input bit h, l, u, b, input int k);
    bus.head = h; bus.left = l; bus.under = u; bus.barrier = b;
    model_step(h, l, u, b, k);
    obs_q.delete();
    foreach (exp_q[i]) begin
      tick();
      obs_q.push_back(observed());
      junk_inputs();
      bus.barrier = bar_q[i];
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    m_virou = 0; m_term = 0; m_passos = 0;
  endtask

  task automatic test_reset();
    bus.head = 0; bus.left = 0; bus.under = 0; bus.barrier = 0;
    Reset = 1'b1;
    tick(); tick();
    checks++;
    if (observed() !== 8'd0) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", observed(), 8'd0);
    end
    checks++;
    if (bus.passos !== 16'd0) begin
      errors++; $display("FAIL reset_passos: got %0d expected 0", bus.passos);
    end
    Reset = 1'b0;
    tick();
    checks++;
    if (bus.estado !== 3'd1) begin
      errors++; $display("FAIL reset_to_decide: got %0d expected 1", bus.estado);
    end
    m_virou = 0; m_term = 0; m_passos = 0;
  endtask

  task automatic test_gira_dir();
    step(1, 1, 0, 0, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL gira_dir cyc%0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_clear_path();
    int start;
    start = m_passos;
    for (int s = 0; s < 10; s++) begin
      step(0, 1, 0, 0, 0);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL clear_path s%0d cyc%0d: got %b expected %b", s, i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (bus.passos !== 16'(start + 10) || m_passos != start + 10) begin
      errors++; $display("FAIL clear_path_passos: got %0d expected %0d", bus.passos, start + 10);
    end
  endtask

  task automatic test_free_left();
    do_reset();
    for (int s = 0; s < 2; s++) begin
      step(0, 0, 0, 0, 0);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL free_left s%0d cyc%0d: got %b expected %b", s, i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (bus.passos !== 16'd1) begin
      errors++; $display("FAIL free_left_passos: got %0d expected 1", bus.passos);
    end
  endtask

  task automatic test_remove();
    do_reset();
    step(0, 1, 0, 1, 10);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL remove_clear cyc%0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    step(0, 1, 0, 1, 17);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL remove_timeout cyc%0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    for (int c = 0; c < 5; c++) begin
      junk_inputs(); bus.barrier = 1'($urandom);
      tick();
      checks++;
      if (observed() !== rec(7, 0, 0, 0, 0, 1)) begin
        errors++; $display("FAIL erro_hold cyc%0d: got %b expected %b", c, observed(), rec(7, 0, 0, 0, 0, 1));
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    step(0, 0, 0, 1, 5);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL left_over_barrier cyc%0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    step(0, 0, 1, 1, 5);
    checks++;
    if (obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL fim_over_barrier: got %b expected %b", obs_q[0], exp_q[0]);
    end
    for (int c = 0; c < 5; c++) begin
      junk_inputs(); bus.barrier = 1'($urandom);
      tick();
      checks++;
      if (observed() !== rec(6, 0, 0, 0, 1, 0)) begin
        errors++; $display("FAIL fim_hold cyc%0d: got %b expected %b", c, observed(), rec(6, 0, 0, 0, 1, 0));
      end
    end
    Reset = 1'b1;
    tick();
    checks++;
    if (observed() !== 8'd0) begin
      errors++; $display("FAIL fim_reset: got %b expected %b", observed(), 8'd0);
    end
    Reset = 1'b0;
    tick();
    checks++;
    if (bus.estado !== 3'd1) begin
      errors++; $display("FAIL fim_reset_decide: got %0d expected 1", bus.estado);
    end
    m_virou = 0; m_term = 0; m_passos = 0;
  endtask

  task automatic test_reset_abort();
    for (int t = 0; t < 2; t++) begin
      do_reset();
      // t=0 enters the right-turn sequence, t=1 enters barrier removal
      bus.head = 1; bus.left = 1; bus.under = 0; bus.barrier = (t == 1);
      tick(); tick(); tick();
      Reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick();
        if (c == 2) Reset = 1'b0;
        checks++;
        if (observed() !== 8'd0) begin
          errors++; $display("FAIL reset_abort t%0d cyc%0d: got %b expected %b", t, c, observed(), 8'd0);
        end
      end
      tick();
      checks++;
      if (observed() !== rec(1, 0, 0, 0, 0, 0)) begin
        errors++; $display("FAIL reset_abort_decide t%0d: got %b expected %b", t, observed(), rec(1, 0, 0, 0, 0, 0));
      end
    end
    m_virou = 0; m_term = 0; m_passos = 0;
  endtask

  task automatic test_random();
    bit h, l, u, b;
    int k;
    do_reset();
    for (int s = 0; s < 120; s++) begin
      if (m_term) do_reset();
      h = 1'($urandom);
      l = 1'($urandom);
      u = ($urandom_range(0, 19) == 0);
      b = ($urandom_range(0, 3) == 0);
      k = $urandom_range(1, 18);
      step(h, l, u, b, k);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL random s%0d cyc%0d: got %b expected %b", s, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (bus.passos !== 16'(m_passos)) begin
        errors++; $display("FAIL random_passos s%0d: got %0d expected %0d", s, bus.passos, m_passos);
      end
    end
  endtask

  initial begin
    test_reset();
    test_gira_dir();
    test_clear_path();
    test_free_left();
    test_remove();
    test_priority();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
